// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data MMUs
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.

package mem_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isWrite;
        logic        isPrivaliged;
        logic        isValid;
    } cpuMemRequest_t;

    typedef struct packed {
        logic [31:0] data;
        logic        isValid;
    } cpuMemResult_t;

endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TimeoutCycles = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  cpuMemRequest_t fetch_request,
    output cpuMemResult_t  fetch_result,
    output logic           fetch_timeout,
    input  cpuMemRequest_t data_request,
    output cpuMemResult_t  data_result,
    output logic           data_timeout,
    output cpuMemRequest_t mem_request,
    input  cpuMemResult_t  mem_result,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        FETCH,
        DATA
    } port_t;

    state_t         state, state_n;
    port_t          owner, owner_n;
    port_t          last_grant, last_grant_n;
    port_t          grant;
    logic           abandoned, abandoned_n;
    logic           owner_live;
    logic           busy_n;
    cpuMemRequest_t mem_request_n;
    cpuMemResult_t  fetch_result_n;
    cpuMemResult_t  data_result_n;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TimeoutCycles - 1);

    logic [15:0] wait_count, wait_count_n;
    logic        fetch_timeout_n, data_timeout_n;
`else
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 16'(TimeoutCycles);
    assign fetch_timeout      = 1'b0;
    assign data_timeout       = 1'b0;
`endif

    assign owner_live = (owner == FETCH) ? fetch_request.isValid : data_request.isValid;

    always_comb begin
        state_n        = state;
        owner_n        = owner;
        last_grant_n   = last_grant;
        abandoned_n    = abandoned;
        grant          = FETCH;
        mem_request_n  = mem_request;
        fetch_result_n = '0;
        data_result_n  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_count_n    = wait_count;
        fetch_timeout_n = 1'b0;
        data_timeout_n  = 1'b0;
`endif

        case (state)
            IDLE: begin
                mem_request_n = '0;
                if (fetch_request.isValid || data_request.isValid) begin
                    if (fetch_request.isValid && data_request.isValid) begin
                        grant = (last_grant == FETCH) ? DATA : FETCH;
                    end else begin
                        grant = fetch_request.isValid ? FETCH : DATA;
                    end
                    mem_request_n         = (grant == FETCH) ? fetch_request : data_request;
                    mem_request_n.isValid = 1'b1;
                    owner_n               = grant;
                    last_grant_n          = grant;
                    abandoned_n           = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_count_n          = '0;
`endif
                    state_n               = WAIT;
                end
            end

            WAIT: begin
                // Once the owner lets go, its result is discarded even if it re-asserts.
                if (!owner_live) begin
                    abandoned_n = 1'b1;
                end
                if (mem_result.isValid) begin
                    mem_request_n = '0;
                    state_n       = DONE;
                    if (owner_live && !abandoned) begin
                        if (owner == FETCH) begin
                            fetch_result_n.data    = mem_result.data;
                            fetch_result_n.isValid = 1'b1;
                        end else begin
                            data_result_n.data    = mem_result.data;
                            data_result_n.isValid = 1'b1;
                        end
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_count == TIMEOUT_LAST) begin
                    mem_request_n = '0;
                    state_n       = DONE;
                    if (owner == FETCH) begin
                        fetch_timeout_n = 1'b1;
                    end else begin
                        data_timeout_n = 1'b1;
                    end
                end else begin
                    wait_count_n = wait_count + 16'd1;
                end
`endif
            end

            DONE: begin
                mem_request_n = '0;
                state_n       = IDLE;
            end

            default: begin
                mem_request_n = '0;
                state_n       = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= FETCH;
            last_grant   <= FETCH;
            abandoned    <= 1'b0;
            mem_request  <= '0;
            fetch_result <= '0;
            data_result  <= '0;
            busy         <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_count    <= '0;
            fetch_timeout <= 1'b0;
            data_timeout  <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            last_grant   <= last_grant_n;
            abandoned    <= abandoned_n;
            mem_request  <= mem_request_n;
            fetch_result <= fetch_result_n;
            data_result  <= data_result_n;
            busy         <= busy_n;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_count    <= wait_count_n;
            fetch_timeout <= fetch_timeout_n;
            data_timeout  <= data_timeout_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic           clock = 1'b0;
    logic           reset;
    cpuMemRequest_t fetch_request, data_request, mem_request;
    cpuMemResult_t  fetch_result, data_result, mem_result;
    logic           fetch_timeout, data_timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.TimeoutCycles(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_request (fetch_request),
        .fetch_result  (fetch_result),
        .fetch_timeout (fetch_timeout),
        .data_request  (data_request),
        .data_result   (data_result),
        .data_timeout  (data_timeout),
        .mem_request   (mem_request),
        .mem_result    (mem_result),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic           rst;
        cpuMemRequest_t f;
        cpuMemRequest_t d;
        cpuMemResult_t  m;
        cpuMemRequest_t e_req;
        cpuMemResult_t  e_f;
        cpuMemResult_t  e_d;
        logic           e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic cpuMemRequest_t rq(logic [31:0] a, logic [31:0] d, logic w, logic p, logic v);
        cpuMemRequest_t r;
        r.addr = a; r.data = d; r.isWrite = w; r.isPrivaliged = p; r.isValid = v;
        return r;
    endfunction

    function automatic cpuMemResult_t rs(logic [31:0] d, logic v);
        cpuMemResult_t r;
        r.data = d; r.isValid = v;
        return r;
    endfunction

    task automatic add(logic rst, cpuMemRequest_t f, cpuMemRequest_t d, cpuMemResult_t m,
                       cpuMemRequest_t er, cpuMemResult_t ef, cpuMemResult_t ed, logic eb);
        vec_t v;
        v.rst = rst; v.f = f; v.d = d; v.m = m;
        v.e_req = er; v.e_f = ef; v.e_d = ed; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(logic rst, cpuMemRequest_t f, cpuMemRequest_t d, cpuMemResult_t m);
        reset = rst; fetch_request = f; data_request = d; mem_result = m;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_req(string name, cpuMemRequest_t act, cpuMemRequest_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_res(string name, cpuMemResult_t act, cpuMemResult_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, cpuMemRequest_t er, cpuMemResult_t ef, cpuMemResult_t ed,
                             logic eb, logic eft, logic edt);
        chk_req({tag, " mem_request"}, mem_request, er);
        chk_res({tag, " fetch_result"}, fetch_result, ef);
        chk_res({tag, " data_result"}, data_result, ed);
        chk_bit({tag, " busy"}, busy, eb);
        chk_bit({tag, " fetch_timeout"}, fetch_timeout, eft);
        chk_bit({tag, " data_timeout"}, data_timeout, edt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cpuMemRequest_t z, f1, f2, d2, d3, f4, d5, f5, d6;
        cpuMemResult_t  zr;
        z  = '0;
        zr = '0;
        f1 = rq(32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b1);
        f2 = rq(32'h0000_00A0, 32'h11, 1'b0, 1'b1, 1'b1);
        d2 = rq(32'h0000_00B0, 32'h22, 1'b1, 1'b0, 1'b1);
        d3 = rq(32'h0000_1000, 32'h55, 1'b1, 1'b0, 1'b1);
        f4 = rq(32'h0000_0300, 32'h0, 1'b0, 1'b1, 1'b1);
        d5 = rq(32'h0000_0400, 32'h44, 1'b0, 1'b0, 1'b1);
        f5 = rq(32'h0000_0500, 32'h0, 1'b0, 1'b0, 1'b1);
        d6 = rq(32'h0000_0600, 32'h66, 1'b1, 1'b1, 1'b1);

        // reset state and a stray response in IDLE
        add(1, z, z, zr, z, zr, zr, 0);
        add(0, z, z, rs(32'h77, 1), z, zr, zr, 0);
        // single fetch, reply two cycles after grant
        add(0, f1, z, zr, f1, zr, zr, 1);
        add(0, f1, z, zr, f1, zr, zr, 1);
        add(0, f1, z, rs(32'hDEAD_BEEF, 1), z, rs(32'hDEAD_BEEF, 1), zr, 1);
        add(0, z, z, zr, z, zr, zr, 0);
        // both ports held from first post-reset IDLE: DATA, FETCH, DATA, FETCH
        add(1, z, z, zr, z, zr, zr, 0);
        add(0, f2, d2, zr, d2, zr, zr, 1);
        add(0, f2, d2, rs(32'h1, 1), z, zr, rs(32'h1, 1), 1);
        add(0, f2, d2, rs(32'h99, 1), z, zr, zr, 0);
        add(0, f2, d2, zr, f2, zr, zr, 1);
        add(0, f2, d2, rs(32'h2, 1), z, rs(32'h2, 1), zr, 1);
        add(0, f2, d2, zr, z, zr, zr, 0);
        add(0, f2, d2, zr, d2, zr, zr, 1);
        add(0, f2, d2, rs(32'h3, 1), z, zr, rs(32'h3, 1), 1);
        add(0, f2, d2, zr, z, zr, zr, 0);
        add(0, f2, d2, zr, f2, zr, zr, 1);
        add(0, f2, d2, rs(32'h4, 1), z, rs(32'h4, 1), zr, 1);
        add(0, z, z, zr, z, zr, zr, 0);
        add(0, z, z, zr, z, zr, zr, 0);

        drive(1, z, z, zr);
        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].f, vecs[i].d, vecs[i].m);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_f, vecs[i].e_d,
                      vecs[i].e_busy, 1'b0, 1'b0);
        end

        // request is latched; live address change during WAIT is not seen
        drive(0, z, d3, zr);
        tick(); check_all("hold_grant", d3, zr, zr, 1, 0, 0);
        data_request.addr = 32'h0000_2000;
        tick(); check_all("hold_wait1", d3, zr, zr, 1, 0, 0);
        tick(); check_all("hold_wait2", d3, zr, zr, 1, 0, 0);
        mem_result = rs(32'h0000_CAFE, 1);
        tick(); check_all("hold_done", z, zr, rs(32'h0000_CAFE, 1), 1, 0, 0);
        drive(0, z, z, zr);
        tick(); check_all("hold_idle", z, zr, zr, 0, 0, 0);

        // fetch abandons its request; reply is swallowed
        drive(0, f4, z, zr);
        tick(); check_all("drop_grant", f4, zr, zr, 1, 0, 0);
        fetch_request = z;
        tick(); check_all("drop_wait", f4, zr, zr, 1, 0, 0);
        mem_result = rs(32'h1234, 1);
        tick(); check_all("drop_done", z, zr, zr, 1, 0, 0);
        mem_result = zr;
        tick(); check_all("drop_idle", z, zr, zr, 0, 0, 0);

        // reset in WAIT, late reply ignored, tie after reset goes to DATA
        drive(0, z, d5, zr);
        tick(); check_all("rst_grant", d5, zr, zr, 1, 0, 0);
        drive(1, z, z, zr);
        tick(); check_all("rst_asserted", z, zr, zr, 0, 0, 0);
        drive(0, z, z, zr);
        tick(); check_all("rst_released", z, zr, zr, 0, 0, 0);
        mem_result = rs(32'h5555, 1);
        tick(); check_all("rst_stray", z, zr, zr, 0, 0, 0);
        drive(0, f5, d5, zr);
        tick(); check_all("rst_tie", d5, zr, zr, 1, 0, 0);
        mem_result = rs(32'h6, 1);
        tick(); check_all("rst_reply", z, zr, rs(32'h6, 1), 1, 0, 0);
        drive(0, z, z, zr);
        tick(); check_all("rst_idle", z, zr, zr, 0, 0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        drive(0, z, d6, zr);
        tick(); check_all("to_grant", d6, zr, zr, 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            tick(); check_all($sformatf("to_wait%0d", k), d6, zr, zr, 1, 0, 0);
        end
        tick(); check_all("to_pulse", z, zr, zr, 1, 0, 1);
        data_request = z;
        tick(); check_all("to_idle", z, zr, zr, 0, 0, 0);

        data_request = d6;
        tick(); check_all("late_grant", d6, zr, zr, 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            tick(); check_all($sformatf("late_wait%0d", k), d6, zr, zr, 1, 0, 0);
        end
        mem_result = rs(32'h8, 1);
        tick(); check_all("late_reply", z, zr, rs(32'h8, 1), 1, 0, 0);
        drive(0, z, z, zr);
        tick(); check_all("late_idle", z, zr, zr, 0, 0, 0);
`else
        drive(0, z, d6, zr);
        tick(); check_all("nowd_grant", d6, zr, zr, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick(); check_all($sformatf("nowd_wait%0d", k), d6, zr, zr, 1, 0, 0);
        end
        mem_result = rs(32'h8, 1);
        tick(); check_all("nowd_reply", z, zr, rs(32'h8, 1), 1, 0, 0);
        drive(0, z, z, zr);
        tick(); check_all("nowd_idle", z, zr, zr, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single `cpuMemRequest_t`/`cpuMemResult_t` memory port between the instruction-side MMU and the data-side MMU. It sits between the two MMU instances' `mem_request`/`mem_result` pins and the memory system. It grants one in-flight request at a time with round-robin fairness and routes each result back only to the owning requester. An optional watchdog aborts transactions that memory never answers.

## Interface
- `TimeoutCycles`, default 255: WAIT cycles before abort; used only with the watchdog. Legal range 1..65535.
- `clock` in, 1: system clock.
- `reset` in, 1: synchronous, active-high.
- `fetch_request` in, `cpuMemRequest_t`: instruction MMU request (`addr`, `data`, `isWrite`, `isPrivaliged`, `isValid`).
- `fetch_result` out, `cpuMemResult_t`: result to the instruction MMU (`data`, `isValid`).
- `fetch_timeout` out, 1: one-cycle abort pulse to the instruction MMU.
- `data_request` in, `cpuMemRequest_t`: data MMU request.
- `data_result` out, `cpuMemResult_t`: result to the data MMU.
- `data_timeout` out, 1: one-cycle abort pulse to the data MMU.
- `mem_request` out, `cpuMemRequest_t`: request to memory.
- `mem_result` in, `cpuMemResult_t`: response from memory.
- `busy` out, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, DONE. Registers: `owner` (FETCH/DATA), `last_grant`, and `wait_count` (16 bits, watchdog only).
- IDLE:
  - No valid request: stay in IDLE. `mem_request` is all-zero.
  - Exactly one valid request: grant it.
  - Both valid: grant the port that is not `last_grant`.
  - On grant: latch the whole request into `mem_request` with `isValid`=1, set `owner` and `last_grant`, clear `wait_count`, go to WAIT.
- WAIT:
  - `mem_request` holds the latched value; the requester's live inputs are not re-sampled.
  - `mem_result.isValid`=1: register `mem_result` into the owner's result with `isValid`=1, clear `mem_request`, go to DONE.
  - Owner drops `isValid` during WAIT: the transaction still completes to memory, the result is discarded, and no result pulse is given.
- DONE: lasts one cycle. Both result ports return to zero. Requests are ignored. Go to IDLE.
  - A requester still asserting `isValid` in the IDLE cycle after DONE is treated as a new request. Requesters must deassert in the cycle they sample their result.
- `mem_result.isValid` arriving in IDLE or DONE is ignored, which covers stray responses after reset.
- The non-owner's result is all-zero at all times.
- `mem_request.isPrivaliged` and `isWrite` pass through unmodified.

## Timing
- Reset values:
  - State IDLE, `last_grant`=FETCH (so DATA wins the first tie), `owner`=FETCH, `wait_count`=0.
  - `mem_request`, `fetch_result` and `data_result` all-zero.
  - `fetch_timeout`, `data_timeout` and `busy` all 0.
- All outputs are registered.
- Request sampled in IDLE at edge N: `mem_request.isValid`=1 from N+1.
- `mem_result.isValid` sampled at edge M: owner result valid for exactly cycle M+1, and `mem_request.isValid`=0 from M+1.
- Minimum spacing: back-to-back grants are at least 3 cycles apart (IDLE→WAIT→DONE→IDLE), plus memory latency.
- Reset asserted mid-transaction: the next edge forces the reset values. The in-flight memory response is dropped per the IDLE rule.
- Round-robin guarantee: under continuous contention, grants alternate strictly, so no port waits more than one foreign transaction.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - In WAIT, `wait_count` increments every cycle without `mem_result.isValid`.
  - When `wait_count` == `TimeoutCycles`-1 and there is still no response: clear `mem_request`, pulse the owner's `*_timeout` for one cycle (result `isValid` stays 0), go to DONE.
  - A response arriving on the same edge as the timeout wins; no timeout pulse is given.
- `MEM_ARB_TIMEOUT_EN` undefined: WAIT has no bound, `wait_count` is not built, and both `*_timeout` outputs are tied 0.

## Test plan
- Single fetch, memory replies 2 cycles later with data 0xDEADBEEF → `fetch_result`={0xDEADBEEF,1} for one cycle; `data_result` stays 0; `busy` falls after DONE.
- Both ports request at the first post-reset IDLE, held through 4 transactions → grant order DATA, FETCH, DATA, FETCH; `mem_request.addr` matches each owner's latched address.
- Data write addr 0x1000, data 0x55, then the data port changes `addr` to 0x2000 during WAIT → `mem_request.addr` stays 0x1000 until completion.
- Fetch drops `isValid` during WAIT, then memory replies → no `fetch_result` pulse; arbiter returns to IDLE 2 cycles after the reply.
- Reset asserted in WAIT, memory replies 1 cycle after reset is released → all outputs zero; reply ignored; a fresh data request is granted normally.
- With `MEM_ARB_TIMEOUT_EN` and `TimeoutCycles`=8, memory never replies → `data_timeout` pulses exactly 8 cycles after WAIT entry and `mem_request.isValid` drops; repeat with a reply on cycle 8 → result delivered, no timeout.
